// File: rtl/plic_prio_if.sv
// ============================================================================
// Module : plic_prio_if
// Brief  : Single-cycle peripheral bus bundle between a bus master and the PLIC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface plic_prio_if;
  logic [23:0] i_addr;
  logic [3:0]  i_we;
  logic [31:0] i_dat_w;
  logic [31:0] o_dat_r;
  logic        i_stb;
  logic        o_ack;

  modport master (
    output i_addr, i_we, i_dat_w, i_stb,
    input  o_dat_r, o_ack
  );

  modport slave (
    input  i_addr, i_we, i_dat_w, i_stb,
    output o_dat_r, o_ack
  );
endinterface

`default_nettype wire

// File: rtl/plic_prio.sv
// ============================================================================
// Module : plic_prio
// Brief  : Platform-level interrupt controller with priority, threshold and claim/complete.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module plic_prio #(
  parameter int          NSRC      = 31,
  parameter int          NCTX      = 2,
  parameter int          PRIO_W    = 3,
  parameter logic [31:0] EDGE_MASK = 32'h0
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  plic_prio_if.slave           bus,
  input  wire logic [NSRC-1:0] i_int,
  output logic      [NCTX-1:0] o_ext_int
);

  localparam int c_ID_W = 8;

  logic [PRIO_W-1:0] r_prio [1:NSRC];
  logic [NSRC:1]     r_en   [NCTX];
  logic [PRIO_W-1:0] r_thr  [NCTX];
  logic [NSRC:1]     r_pend;
  logic [NSRC:1]     r_infl;
  logic [NSRC:1]     r_defer;
  logic [NSRC:1]     r_hist;
  logic [NCTX-1:0]   r_ext_int;

  logic              w_wr;
  logic              w_rd;
  logic              w_prio_sel;
  logic              w_pend_sel;
  logic              w_en_sel;
  logic              w_ctx_sel;
  logic              w_is_claim;
  logic [9:0]        w_prio_id;
  logic [4:0]        w_en_ctx;
  logic [2:0]        w_ctx;
  logic [c_ID_W-1:0] w_best_id [NCTX];
  logic [PRIO_W-1:0] w_best_pr [NCTX];
  logic [c_ID_W-1:0] w_claim_id;
  logic [NSRC:1]     w_comp_hit;
  logic [NSRC:1]     w_rise;
  logic [NSRC:1]     w_pend_nxt;
  logic [NSRC:1]     w_infl_nxt;
  logic [NSRC:1]     w_defer_nxt;
  logic [31:0]       w_dat_r;

  // Address decode; only word-aligned accesses hit a register.
  assign w_wr       = bus.i_stb & (|bus.i_we);
  assign w_rd       = bus.i_stb & (bus.i_we == 4'h0);
  assign w_prio_sel = (bus.i_addr[23:12] == 12'h000) && (bus.i_addr[1:0] == 2'b00);
  assign w_prio_id  = bus.i_addr[11:2];
  assign w_pend_sel = (bus.i_addr == 24'h001000);
  assign w_en_sel   = (bus.i_addr[23:12] == 12'h002) && (bus.i_addr[6:0] == 7'h00);
  assign w_en_ctx   = bus.i_addr[11:7];
  assign w_ctx_sel  = (bus.i_addr[23:15] == 9'h040) && (bus.i_addr[11:3] == 9'h000)
                      && (bus.i_addr[1:0] == 2'b00);
  assign w_ctx      = bus.i_addr[14:12];
  assign w_is_claim = bus.i_addr[2];

  // Best candidate per context: strict '>' keeps the lowest id on priority ties.
  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      w_best_id[c] = '0;
      w_best_pr[c] = '0;
      for (int id = 1; id <= NSRC; id++) begin
        if (r_pend[id] && r_en[c][id] && (r_prio[id] > r_thr[c]) &&
            ((w_best_id[c] == '0) || (r_prio[id] > w_best_pr[c]))) begin
          w_best_id[c] = c_ID_W'(id);
          w_best_pr[c] = r_prio[id];
        end
      end
    end
  end

  always_comb begin
    w_claim_id = '0;
    w_comp_hit = '0;
    for (int c = 0; c < NCTX; c++) begin
      if (w_ctx_sel && w_is_claim && (w_ctx == 3'(c))) begin
        if (w_rd) begin
          w_claim_id = w_best_id[c];
        end
        if (w_wr) begin
          for (int id = 1; id <= NSRC; id++) begin
            if ((bus.i_dat_w[7:0] == 8'(id)) && r_en[c][id] && r_infl[id]) begin
              w_comp_hit[id] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_rise = '0;
    for (int id = 1; id <= NSRC; id++) begin
      w_rise[id] = EDGE_MASK[id] & i_int[id-1] & ~r_hist[id];
    end
  end

  // Gateways: completion releases first, then new events, and a claim overrides both.
  always_comb begin
    w_pend_nxt  = r_pend;
    w_infl_nxt  = r_infl;
    w_defer_nxt = r_defer;
    for (int id = 1; id <= NSRC; id++) begin
      if (w_comp_hit[id]) begin
        w_infl_nxt[id] = 1'b0;
        if (r_defer[id]) begin
          w_pend_nxt[id]  = 1'b1;
          w_defer_nxt[id] = 1'b0;
        end
      end
      if (EDGE_MASK[id]) begin
        if (w_rise[id]) begin
          if (!r_pend[id] && !r_infl[id]) begin
            w_pend_nxt[id] = 1'b1;
          end else begin
            w_defer_nxt[id] = 1'b1;
          end
        end
      end else if (i_int[id-1] && !r_pend[id] && !r_infl[id]) begin
        w_pend_nxt[id] = 1'b1;
      end
      if (w_claim_id == c_ID_W'(id)) begin
        w_pend_nxt[id] = 1'b0;
        w_infl_nxt[id] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend    <= '0;
      r_infl    <= '0;
      r_defer   <= '0;
      r_hist    <= '0;
      r_ext_int <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_infl  <= w_infl_nxt;
      r_defer <= w_defer_nxt;
      r_hist  <= i_int;
      for (int c = 0; c < NCTX; c++) begin
        r_ext_int[c] <= (w_best_id[c] != '0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int id = 1; id <= NSRC; id++) begin
        r_prio[id] <= '0;
      end
      for (int c = 0; c < NCTX; c++) begin
        r_en[c]  <= '0;
        r_thr[c] <= '0;
      end
    end else if (w_wr) begin
      for (int id = 1; id <= NSRC; id++) begin
        if (w_prio_sel && (w_prio_id == 10'(id))) begin
          r_prio[id] <= bus.i_dat_w[PRIO_W-1:0];
        end
      end
      for (int c = 0; c < NCTX; c++) begin
        if (w_en_sel && (w_en_ctx == 5'(c))) begin
          for (int id = 1; id <= NSRC; id++) begin
            if (bus.i_we[id/8]) begin
              r_en[c][id] <= bus.i_dat_w[id];
            end
          end
        end
        if (w_ctx_sel && !w_is_claim && (w_ctx == 3'(c))) begin
          r_thr[c] <= bus.i_dat_w[PRIO_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_dat_r = '0;
    if (w_prio_sel) begin
      for (int id = 1; id <= NSRC; id++) begin
        if (w_prio_id == 10'(id)) begin
          w_dat_r = 32'(r_prio[id]);
        end
      end
    end
    if (w_pend_sel) begin
      w_dat_r = 32'({r_pend, 1'b0});
    end
    for (int c = 0; c < NCTX; c++) begin
      if (w_en_sel && (w_en_ctx == 5'(c))) begin
        w_dat_r = 32'({r_en[c], 1'b0});
      end
      if (w_ctx_sel && (w_ctx == 3'(c))) begin
        w_dat_r = w_is_claim ? 32'(w_best_id[c]) : 32'(r_thr[c]);
      end
    end
  end

  assign bus.o_dat_r = w_dat_r;
  assign bus.o_ack   = bus.i_stb;
  assign o_ext_int   = r_ext_int;

endmodule

`default_nettype wire

// File: tb/tb_plic_prio.sv
// ============================================================================
// Module : tb_plic_prio
// Brief  : Directed self-checking bench for plic_prio (31 sources, 2 contexts, src4 edge).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_plic_prio;
  localparam int          NSRC      = 31;
  localparam int          NCTX      = 2;
  localparam int          PRIO_W    = 3;
  localparam logic [31:0] EDGE_MASK = 32'h0000_0010;

  localparam logic [23:0] c_PEND = 24'h001000;
  localparam logic [23:0] c_EN0  = 24'h002000;
  localparam logic [23:0] c_EN1  = 24'h002080;
  localparam logic [23:0] c_THR0 = 24'h200000;
  localparam logic [23:0] c_THR1 = 24'h201000;
  localparam logic [23:0] c_CLM0 = 24'h200004;
  localparam logic [23:0] c_CLM1 = 24'h201004;

  logic            clk;
  logic            rst_n;
  logic [NSRC-1:0] r_int;
  logic [NCTX-1:0] w_ext_int;
  logic [31:0]     r_rd;
  int              checks;
  int              errors;

  plic_prio_if bus ();

  plic_prio #(
    .NSRC      (NSRC),
    .NCTX      (NCTX),
    .PRIO_W    (PRIO_W),
    .EDGE_MASK (EDGE_MASK)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus.slave),
    .i_int     (r_int),
    .o_ext_int (w_ext_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [23:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.i_addr  = addr;
    bus.i_dat_w = data;
    bus.i_we    = 4'hF;
    bus.i_stb   = 1'b1;
    @(posedge clk);
    #1;
    bus.i_stb = 1'b0;
    bus.i_we  = 4'h0;
  endtask

  task automatic bus_rd(input logic [23:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.i_addr = addr;
    bus.i_we   = 4'h0;
    bus.i_stb  = 1'b1;
    #1;
    data = bus.o_dat_r;
    @(posedge clk);
    #1;
    bus.i_stb = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic level_pulse(input int id);
    @(negedge clk);
    r_int[id-1] = 1'b1;
    wait_cyc(2);
    r_int[id-1] = 1'b0;
  endtask

  task automatic edge_pulse(input int id);
    @(negedge clk);
    r_int[id-1] = 1'b1;
    @(negedge clk);
    r_int[id-1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    r_int       = '0;
    bus.i_addr  = '0;
    bus.i_we    = 4'h0;
    bus.i_dat_w = '0;
    bus.i_stb   = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);
    check("rst_ext", 32'(w_ext_int), 32'h0);

    // Level source 3, in-flight blocking and re-pend after complete
    bus_wr(24'h00000C, 32'h2);
    bus_wr(c_EN0, 32'h0000_0009);
    bus_rd(c_EN0, r_rd);
    check("en0_bit0_forced", r_rd, 32'h8);
    bus_wr(c_THR0, 32'h0);
    @(negedge clk);
    r_int[2] = 1'b1;
    wait_cyc(3);
    check("lvl_irq", 32'(w_ext_int), 32'h1);
    bus_rd(c_CLM0, r_rd);
    check("lvl_claim", r_rd, 32'd3);
    wait_cyc(2);
    check("lvl_blocked_irq", 32'(w_ext_int), 32'h0);
    bus_rd(c_PEND, r_rd);
    check("lvl_blocked_pend", r_rd, 32'h0);
    bus_wr(c_CLM0, 32'd3);
    wait_cyc(3);
    check("lvl_repend_irq", 32'(w_ext_int), 32'h1);
    r_int[2] = 1'b0;
    bus_rd(c_CLM0, r_rd);
    check("lvl_claim2", r_rd, 32'd3);
    bus_wr(c_CLM0, 32'd3);
    wait_cyc(2);
    check("lvl_idle", 32'(w_ext_int), 32'h0);

    // Priority ordering on context 1 and threshold masking
    bus_wr(24'h000014, 32'h1);
    bus_wr(24'h000024, 32'h4);
    bus_rd(24'h000024, r_rd);
    check("prio9_rd", r_rd, 32'h4);
    bus_wr(c_EN1, 32'h0000_0220);
    bus_wr(c_THR1, 32'h0);
    @(negedge clk);
    r_int[4] = 1'b1;
    r_int[8] = 1'b1;
    wait_cyc(2);
    r_int[4] = 1'b0;
    r_int[8] = 1'b0;
    wait_cyc(1);
    check("prio_irq", 32'(w_ext_int), 32'h2);
    bus_rd(c_CLM1, r_rd);
    check("prio_first", r_rd, 32'd9);
    bus_rd(c_CLM1, r_rd);
    check("prio_second", r_rd, 32'd5);
    bus_wr(c_CLM1, 32'd9);
    bus_wr(c_CLM1, 32'd5);
    bus_wr(c_THR1, 32'h4);
    bus_rd(c_THR1, r_rd);
    check("thr1_rd", r_rd, 32'h4);
    level_pulse(9);
    wait_cyc(2);
    check("thr_no_irq", 32'(w_ext_int), 32'h0);
    bus_rd(c_CLM1, r_rd);
    check("thr_claim0", r_rd, 32'd0);
    bus_rd(c_PEND, r_rd);
    check("thr_pend_kept", r_rd, 32'h0000_0200);
    bus_wr(c_THR1, 32'h0);
    bus_rd(c_CLM1, r_rd);
    check("thr_claim9", r_rd, 32'd9);
    bus_wr(c_CLM1, 32'd9);

    // Equal priorities resolve to the lowest id
    bus_wr(24'h000008, 32'h3);
    bus_wr(24'h00001C, 32'h3);
    bus_wr(c_EN0, 32'h0000_008C);
    @(negedge clk);
    r_int[1] = 1'b1;
    r_int[6] = 1'b1;
    wait_cyc(2);
    r_int[1] = 1'b0;
    r_int[6] = 1'b0;
    bus_rd(c_CLM0, r_rd);
    check("tie_first", r_rd, 32'd2);
    bus_rd(c_CLM0, r_rd);
    check("tie_second", r_rd, 32'd7);
    bus_wr(c_CLM0, 32'd2);
    bus_wr(c_CLM0, 32'd7);

    // Edge source 4 with a single level of deferral
    bus_wr(24'h000010, 32'h5);
    bus_wr(c_EN0, 32'h0000_009C);
    edge_pulse(4);
    wait_cyc(1);
    check("edge_irq", 32'(w_ext_int), 32'h1);
    bus_rd(c_CLM0, r_rd);
    check("edge_claim", r_rd, 32'd4);
    edge_pulse(4);
    edge_pulse(4);
    wait_cyc(1);
    check("edge_defer_irq", 32'(w_ext_int), 32'h0);
    bus_rd(c_PEND, r_rd);
    check("edge_defer_pend", r_rd, 32'h0);
    bus_wr(c_CLM0, 32'd4);
    wait_cyc(2);
    check("edge_redo_irq", 32'(w_ext_int), 32'h1);
    bus_rd(c_PEND, r_rd);
    check("edge_redo_pend", r_rd, 32'h0000_0010);
    bus_rd(c_CLM0, r_rd);
    check("edge_claim2", r_rd, 32'd4);
    bus_wr(c_CLM0, 32'd4);
    wait_cyc(2);
    check("edge_idle_irq", 32'(w_ext_int), 32'h0);
    bus_rd(c_CLM0, r_rd);
    check("edge_idle_claim", r_rd, 32'd0);

    // Completes that must be ignored: disabled in ctx, or not in flight
    bus_wr(24'h000030, 32'h2);
    bus_wr(c_EN1, 32'h0000_1220);
    level_pulse(12);
    bus_rd(c_CLM1, r_rd);
    check("bad_claim12", r_rd, 32'd12);
    bus_wr(c_CLM0, 32'd12);
    bus_wr(c_CLM1, 32'd13);
    bus_wr(c_CLM1, 32'd0);
    level_pulse(12);
    wait_cyc(1);
    bus_rd(c_PEND, r_rd);
    check("bad_cpl_still_flight", r_rd, 32'h0);
    bus_wr(c_CLM1, 32'd12);
    level_pulse(12);
    wait_cyc(1);
    bus_rd(c_PEND, r_rd);
    check("good_cpl_repend", r_rd, 32'h0000_1000);
    check("good_cpl_irq", 32'(w_ext_int), 32'h2);

    // Asynchronous reset in the middle of a claim read
    @(negedge clk);
    bus.i_addr = c_CLM1;
    bus.i_we   = 4'h0;
    bus.i_stb  = 1'b1;
    #1;
    check("mid_claim_rd", bus.o_dat_r, 32'd12);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_irq", 32'(w_ext_int), 32'h0);
    check("rst_async_claim", bus.o_dat_r, 32'h0);
    bus.i_stb = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    check("rst_post_irq", 32'(w_ext_int), 32'h0);
    bus_rd(24'h000030, r_rd);
    check("rst_prio12", r_rd, 32'h0);
    bus_rd(c_EN1, r_rd);
    check("rst_en1", r_rd, 32'h0);
    bus_rd(c_PEND, r_rd);
    check("rst_pend", r_rd, 32'h0);
    bus_rd(c_CLM1, r_rd);
    check("rst_claim", r_rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
